// File: rtl/window_seq_if.sv
// Handshake/bus bundle for window_seq_ctrl.
// master: frame/pixel source side (drives start, cont, vsync, pix_valid, pix_data).
// slave : sequencer side (drives line-buffer, window and status outputs).
// When WINDOW_STATS_EN is defined the bundle also carries win_count[19:0].
interface window_seq_if #(
    parameter int unsigned DW = 12,
    parameter int unsigned CW = 10
) ();
    logic          start;
    logic          cont;
    logic          vsync;
    logic          pix_valid;
    logic [DW-1:0] pix_data;

    logic          lb_valid;
    logic [DW-1:0] lb_data;
    logic          lb_clear;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          win_valid;
    logic [CW-1:0] win_col;
    logic [CW-1:0] win_row;
    logic          busy;
    logic          frame_done;
    logic          frame_err;
`ifdef WINDOW_STATS_EN
    logic [19:0]   win_count;
`endif

    modport master (
        output start, cont, vsync, pix_valid, pix_data,
        input  lb_valid, lb_data, lb_clear, col, row,
        input  win_valid, win_col, win_row, busy, frame_done, frame_err
`ifdef WINDOW_STATS_EN
        , input win_count
`endif
    );

    modport slave (
        input  start, cont, vsync, pix_valid, pix_data,
        output lb_valid, lb_data, lb_clear, col, row,
        output win_valid, win_col, win_row, busy, frame_done, frame_err
`ifdef WINDOW_STATS_EN
        , output win_count
`endif
    );
endinterface

// File: rtl/window_seq_ctrl.sv
// Frame sequencer for the 3x3 line-buffer window generator.
// Arms on start, syncs to camera vsync, gates pixels into the line-buffer
// chain with column/row tags, flushes the buffers at frame start and flags
// each pixel that completes a 3x3 window (with the window centre).
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - window_seq_if.slave:
//          in : start, cont, vsync, pix_valid, pix_data[DW]
//          out: lb_valid, lb_data[DW], lb_clear, col[CW], row[CW],
//               win_valid, win_col[CW], win_row[CW], busy,
//               frame_done, frame_err
//               win_count[20] (only with WINDOW_STATS_EN)
//
// Optional feature macro: WINDOW_STATS_EN (per-frame window count).
// CW must satisfy 2^CW > max(COL_NUM, ROW_NUM).
module window_seq_ctrl #(
    parameter int unsigned DW      = 12,
    parameter int unsigned COL_NUM = 640,
    parameter int unsigned ROW_NUM = 480,
    parameter int unsigned CW      = 10
) (
    input  logic        clk,
    input  logic        rst,
    window_seq_if.slave bus
);
    localparam logic [CW-1:0] COL_LAST = CW'(COL_NUM - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(ROW_NUM - 1);
    localparam logic [CW-1:0] WIN_MIN  = CW'(2);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        SYNC   = 3'd2,
        ACTIVE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state;
    logic          vsync_q;
    logic          first_q;
    logic [CW-1:0] col_cnt;
    logic [CW-1:0] row_cnt;

    logic          lb_valid_q;
    logic [DW-1:0] lb_data_q;
    logic          lb_clear_q;
    logic [CW-1:0] col_q;
    logic [CW-1:0] row_q;
    logic          win_valid_q;
    logic [CW-1:0] win_col_q;
    logic [CW-1:0] win_row_q;
    logic          busy_q;
    logic          frame_done_q;
    logic          frame_err_q;

    logic          vs_rise_c;
    logic          vs_fall_c;
    logic          last_c;
    logic          win_c;

    assign vs_rise_c = bus.vsync & ~vsync_q;
    assign vs_fall_c = ~bus.vsync & vsync_q;
    assign last_c    = (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
    assign win_c     = (col_cnt >= WIN_MIN) && (row_cnt >= WIN_MIN);

    // Sequencer state, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            vsync_q      <= 1'b0;
            first_q      <= 1'b0;
            col_cnt      <= '0;
            row_cnt      <= '0;
            lb_valid_q   <= 1'b0;
            lb_data_q    <= '0;
            lb_clear_q   <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            win_col_q    <= '0;
            win_row_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            vsync_q      <= bus.vsync;
            lb_valid_q   <= 1'b0;
            lb_clear_q   <= 1'b0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= ARMED;
                        busy_q <= 1'b1;
                    end
                end

                ARMED: begin
                    if (vs_rise_c) begin
                        state <= SYNC;
                    end
                end

                SYNC: begin
                    if (vs_fall_c) begin
                        state   <= ACTIVE;
                        col_cnt <= '0;
                        row_cnt <= '0;
                        first_q <= 1'b1;
                    end
                end

                ACTIVE: begin
                    // Flush is issued out of the first ACTIVE cycle, aligned
                    // with that cycle's (possible) pixel write.
                    first_q    <= 1'b0;
                    lb_clear_q <= first_q;
                    // The last pixel completes the frame even if vsync rises with it.
                    if (bus.pix_valid && (last_c || !vs_rise_c)) begin
                        lb_valid_q  <= 1'b1;
                        lb_data_q   <= bus.pix_data;
                        col_q       <= col_cnt;
                        row_q       <= row_cnt;
                        win_valid_q <= win_c;
                        if (win_c) begin
                            win_col_q <= col_cnt - ONE;
                            win_row_q <= row_cnt - ONE;
                        end
                        if (col_cnt == COL_LAST) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + ONE;
                        end else begin
                            col_cnt <= col_cnt + ONE;
                        end
                        if (last_c) begin
                            frame_done_q <= 1'b1;
                            state        <= DONE;
                        end
                    end else if (vs_rise_c) begin
                        // Early vsync: abandon this frame and resync.
                        frame_err_q <= 1'b1;
                        state       <= SYNC;
                    end
                end

                DONE: begin
                    if (bus.cont) begin
                        state <= ARMED;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lb_valid   = lb_valid_q;
    assign bus.lb_data    = lb_data_q;
    assign bus.lb_clear   = lb_clear_q;
    assign bus.col        = col_q;
    assign bus.row        = row_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_col    = win_col_q;
    assign bus.win_row    = win_row_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;

`ifdef WINDOW_STATS_EN
    logic [19:0] win_run_q;
    logic [19:0] win_count_q;

    // Running window count per frame; published only on a clean frame end.
    // frame_done coincides with the final window, so that one is added in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_run_q   <= '0;
            win_count_q <= '0;
        end else begin
            if (lb_clear_q) begin
                win_run_q <= '0;
            end else if (win_valid_q) begin
                win_run_q <= win_run_q + 20'd1;
            end
            if (frame_done_q) begin
                win_count_q <= win_run_q + 20'(win_valid_q);
            end
        end
    end

    assign bus.win_count = win_count_q;
`endif

endmodule

// File: doc/window_seq_ctrl.md
Name: window_seq_ctrl

Overview:
- Frame sequencer for the 3x3 line-buffer window generator in the camera-to-VGA filter path.
- Arms on request, syncs to the camera vsync and gates pixel writes into the line-buffer chain.
- Counts column and row, flushes the buffers at frame start, and flags when a complete 3x3 window (with its centre coordinate) is available to the downstream filter.

Parameters:
- DW, 12, pixel width (RGB444).
- COL_NUM, 640, active pixels per line.
- ROW_NUM, 480, active lines per frame.
- CW, 10, column/row counter width; must satisfy 2^CW > max(COL_NUM, ROW_NUM).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle request to capture the next frame.
- cont  in  1  continuous mode: re-arm automatically after each frame.
- vsync  in  1  camera frame sync; high between frames.
- pix_valid  in  1  pixel present on pix_data this cycle.
- pix_data  in  DW  incoming pixel.
- lb_valid  out  1  write enable to the line-buffer chain.
- lb_data  out  DW  pixel to the line-buffer chain.
- lb_clear  out  1  one-cycle flush pulse to the line buffers.
- col  out  CW  column of the pixel on lb_data.
- row  out  CW  row of the pixel on lb_data.
- win_valid  out  1  3x3 window completed by this lb_data pixel.
- win_col  out  CW  window centre column.
- win_row  out  CW  window centre row.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse at clean frame end.
- frame_err  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; internal counters 0. Reset asserted mid-frame drops the frame silently, with no frame_done and no frame_err.
- FSM states: IDLE, ARMED, SYNC, ACTIVE, DONE.
- IDLE -> ARMED on start=1. start is ignored in every other state.
- ARMED -> SYNC on vsync 0->1 edge (vsync registered once for edge detection). A vsync already high when armed does not count; wait for the next rising edge.
- SYNC -> ACTIVE on vsync 1->0 edge.
  - Counters cleared.
  - lb_clear=1 for exactly the first ACTIVE cycle.
- ACTIVE, per accepted pixel (pix_valid=1):
  - Registered outputs, 1-cycle latency: lb_valid=1, lb_data=pix_data, col/row = pre-increment counters.
  - Column wraps COL_NUM-1 -> 0 and increments the row.
  - pix_valid=0: lb_valid=0; counters and lb_data hold.
- win_valid is registered alongside lb_valid.
  - Asserted iff the pixel is accepted and row>=2 and col>=2.
  - win_col=col-1, win_row=row-1.
  - Gives (COL_NUM-2)*(ROW_NUM-2) windows per frame.
  - win_col/win_row hold their last values while win_valid=0.
- pix_valid outside ACTIVE is ignored: no lb_valid, no counting.
- Last pixel accepted (row=ROW_NUM-1, col=COL_NUM-1) -> DONE.
  - frame_done=1 for one cycle, coincident with that pixel's lb_valid/win_valid.
  - DONE -> ARMED if cont=1, else -> IDLE, next cycle.
- vsync rising edge while ACTIVE before the last pixel: frame_err pulse for one cycle, no frame_done, go directly to SYNC (frame restart, lb_clear on re-entry to ACTIVE).
- vsync rising edge coincident with last-pixel acceptance: the pixel completes the frame; frame_done wins, frame_err=0, then the DONE transition applies.
- lb_clear and lb_valid may be high in the same cycle only if pix_valid was high on the first ACTIVE cycle. The line buffer must treat clear as applying before the write.
- busy=0 only in IDLE.

Optional Feature:
- Macro: WINDOW_STATS_EN.
- Defined:
  - Adds output win_count [19:0].
  - A running counter increments on each win_valid and clears on lb_clear.
  - Its value is captured to win_count at frame_done and holds until the next frame_done.
  - Reset value is 0. Aborted frames do not update win_count.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (COL_NUM=8, ROW_NUM=6, CW=4):
- Reset, start, vsync pulse, 48 pixels with pix_valid=1 continuous -> lb_clear once; 48 lb_valid; 24 win_valid, first at col=2,row=2 with win=(1,1), last win=(6,4); frame_done on the 48th lb_valid; busy falls the cycle after.
- Same frame with pix_valid toggling 1/0 -> identical col/row/win sequence, lb_data matches inputs in order, no count on idle cycles.
- cont=1, two back-to-back frames -> two frame_done pulses, ARMED between frames, counters restart at 0,0, second lb_clear seen. With WINDOW_STATS_EN, win_count=24 after each frame.
- vsync rises after 20 pixels -> frame_err pulse, no frame_done, SYNC entered. After vsync falls, a full 48-pixel frame -> frame_done, with WINDOW_STATS_EN win_count=24 (not 24+aborted).
- pix_valid=1 while IDLE/ARMED/SYNC, start pulsed while ACTIVE -> lb_valid stays 0 outside ACTIVE; start ignored; frame unaffected.
- rst asserted at pixel 30 -> all outputs 0 immediately (async), state IDLE, no frame_done/frame_err. After release, a fresh start plus frame completes normally.
